post_sparsity_param: RTL and testbench
======================================

POST_SPARSITY_PARAM -- requirements
Module: post_sparsity_param

Interface
REQ-001 Parameter IL, default 4: integer bits of signed fixed-point data.
REQ-002 Parameter FL, default 16: fraction bits; data width W = IL+FL.
REQ-003 Parameter LANES, default 16: number of compressed data lanes.
REQ-004 Parameter LENGTH, default 32: dense mask length (LENGTH >= LANES).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 i_im  in  LANES x W signed  compressed input values; lane k belongs to the k-th set bit of i_mask, counted from the LSB.
REQ-008 i_mask  in  LENGTH  dense occupancy mask of the input vector.
REQ-009 i_mode  in  1  0 = prune exact zeros only; 1 = prune by magnitude threshold.
REQ-010 i_threshold  in  W unsigned  magnitude threshold used when i_mode=1.
REQ-011 input_ready  in  1  load request; honoured only in IDLE.
REQ-012 output_taken  in  1  consumer acknowledge; honoured only in DONE.
REQ-013 o_im  out  LANES x W signed  recompressed values, lowest lanes first, zero-filled above o_count.
REQ-014 o_mask  out  LENGTH  updated dense mask.
REQ-015 o_count  out  clog2(LANES+1)  number of surviving values.
REQ-016 o_overflow  out  1  popcount(i_mask) > LANES on the last load.
REQ-017 state  out  2  FSM state: IDLE=00, COMPUTE=01, DONE=10; 11 is never reached.

Function
REQ-018 IDLE with input_ready=1 at an edge: the block SHALL capture i_im, i_mask, i_mode and i_threshold into internal registers and enter COMPUTE.
REQ-019 COMPUTE SHALL process exactly one lane per cycle, lanes 0..LANES-1 in order.
REQ-020 State SHALL be DONE at the LANES-th edge after the load edge; latency is fixed and independent of the data.
REQ-021 Lane k pairing: lane k SHALL pair with mask bit position p_k, the k-th set bit of the captured mask.
REQ-022 Pairing implementation: a shadow mask SHALL be consumed by clearing its lowest set bit each cycle.
REQ-023 If no set bit remains for lane k, lane k SHALL be ignored.
REQ-024 Prune rule, mode 0: a lane SHALL be pruned iff its value == 0.
REQ-025 Prune rule, mode 1: a lane SHALL be pruned iff |value| < i_threshold (strictly less).
REQ-026 Magnitude of the most negative value SHALL saturate to 2^(W-1)-1 before comparison.
REQ-027 A pruned lane SHALL clear mask bit p_k and SHALL NOT advance the write index.
REQ-028 A surviving lane SHALL be written to output slot [write index], and the write index SHALL increment.
REQ-029 Overflow: set mask bits beyond the LANES-th set bit have no data; they SHALL be cleared in o_mask, and o_overflow SHALL be 1.
REQ-030 o_im, o_mask, o_count and o_overflow SHALL update only on the edge entering DONE, and SHALL hold until the next entry into DONE.
REQ-031 DONE with output_taken=1: the block SHALL return to IDLE.
REQ-032 DONE with output_taken=0: the block SHALL remain in DONE indefinitely.
REQ-033 input_ready SHALL be ignored in COMPUTE and in DONE, including when asserted together with output_taken; the next load is accepted no earlier than the cycle after the return to IDLE.
REQ-034 output_taken SHALL be ignored outside DONE.
REQ-035 An all-zero i_mask SHALL still take LANES cycles and SHALL produce o_mask=0, o_count=0 and o_im all zero.

Reset
REQ-036 On reset=1 at an edge, the block SHALL force state=IDLE and o_im all zero, o_mask=0, o_count=0, o_overflow=0.
REQ-037 Reset SHALL clear all internal capture, shadow-mask and index registers.
REQ-038 Reset asserted during COMPUTE or DONE SHALL abort the operation with no partial outputs.
REQ-039 Reset SHALL take priority over input_ready and output_taken.

Verification
REQ-040 Zero-prune case: mode 0, i_mask=0x0000FFFF, i_im[j]=j+1 except lanes 5,7,8,11,15 = 0 -> DONE 16 cycles after load; o_mask=0x0000765F; o_count=11; o_im[0..10]=1,2,3,4,5,7,10,11,13,14,15; o_im[11..15]=0; o_overflow=0.
REQ-041 Overflow case: mode 0, i_mask=0xFFFFFFFF, all i_im nonzero -> o_mask=0x0000FFFF, o_count=16, o_overflow=1.
REQ-042 Threshold case: mode 1, i_threshold=4 (raw), i_mask=0x000000F0, i_im[0..3]=1,-5,3,4 -> o_mask=0x000000A0, o_count=2, o_im[0]=-5, o_im[1]=4, others 0.
REQ-043 Handshake case: hold output_taken=0 for 10 cycles in DONE -> state stays 10 and outputs are stable; pulse input_ready during COMPUTE and DONE -> no reload; assert output_taken -> IDLE on the next edge.
REQ-044 Reset-abort case: assert reset on the 5th COMPUTE cycle -> state=00 and all outputs zero on the next edge; a subsequent load completes normally.

Source files
------------

// File: rtl/post_sparsity_param.sv
// rtl/post_sparsity_param.sv - sparse vector re-pruning and recompression engine
module post_sparsity_param #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LANES  = 16,
  parameter int LENGTH = 32,
  localparam int W     = IL + FL,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES*W-1:0] i_im,
  input  logic [LENGTH-1:0]  i_mask,
  input  logic               i_mode,
  input  logic [W-1:0]       i_threshold,
  input  logic               input_ready,
  input  logic               output_taken,
  output logic [LANES*W-1:0] o_im,
  output logic [LENGTH-1:0]  o_mask,
  output logic [CW-1:0]      o_count,
  output logic               o_overflow,
  output logic [1:0]         state
);

  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COMPUTE = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  localparam logic [LIW-1:0] LAST_LANE = LIW'(LANES - 1);
  localparam logic [W-1:0]   MOST_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   MAX_POS   = {1'b0, {(W-1){1'b1}}};

  logic [1:0]         state_next;
  logic               load_en;
  logic               step_en;
  logic               finish_en;

  // captured operands and working registers
  logic [LANES*W-1:0] cap_im;
  logic               cap_mode;
  logic [W-1:0]       cap_thr;
  logic [LENGTH-1:0]  shadow;
  logic [LENGTH-1:0]  work;
  logic [LIW-1:0]     lane_idx;
  logic [CW-1:0]      wr_idx;
  logic [LANES*W-1:0] acc_im;

  // per-lane combinational results
  logic [W-1:0]       lane_val;
  logic [W-1:0]       mag;
  logic               prune;
  logic               has_bit;
  logic               keep;
  logic [LENGTH-1:0]  lsb;
  logic [LENGTH-1:0]  shadow_next;
  logic [LENGTH-1:0]  work_next;
  logic [CW-1:0]      wr_next;
  logic [LANES*W-1:0] acc_next;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; input_ready only matters in IDLE, output_taken only in DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (input_ready) state_next = ST_COMPUTE;
      ST_COMPUTE: if (lane_idx == LAST_LANE) state_next = ST_DONE;
      ST_DONE:    if (output_taken) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // FSM-decoded control strobes for the datapath
  always_comb begin
    load_en   = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    if (state == ST_IDLE && input_ready) load_en = 1'b1;
    if (state == ST_COMPUTE) begin
      step_en   = 1'b1;
      finish_en = (lane_idx == LAST_LANE);
    end
  end

  // select the compressed value for the lane being processed this cycle
  always_comb begin
    lane_val = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_idx == LIW'(k)) lane_val = cap_im[k*W +: W];
    end
  end

  // magnitude with the most negative code saturated so it stays representable
  always_comb begin
    if (lane_val == MOST_NEG) begin
      mag = MAX_POS;
    end else if (lane_val[W-1]) begin
      mag = -lane_val;
    end else begin
      mag = lane_val;
    end
  end

  // pair lane with lowest remaining mask bit, decide prune, build next working state
  always_comb begin
    prune       = cap_mode ? (mag < cap_thr) : (lane_val == '0);
    has_bit     = |shadow;
    lsb         = shadow & (~shadow + LENGTH'(1));
    shadow_next = shadow & ~lsb;
    keep        = has_bit && !prune;
    work_next   = (has_bit && prune) ? (work & ~lsb) : work;
    wr_next     = keep ? (wr_idx + CW'(1)) : wr_idx;
    acc_next    = acc_im;
    for (int s = 0; s < LANES; s++) begin
      if (keep && wr_idx == CW'(s)) acc_next[s*W +: W] = lane_val;
    end
  end

  // capture on load, advance one lane per COMPUTE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_im   <= '0;
      cap_mode <= 1'b0;
      cap_thr  <= '0;
      shadow   <= '0;
      work     <= '0;
      lane_idx <= '0;
      wr_idx   <= '0;
      acc_im   <= '0;
    end else if (load_en) begin
      cap_im   <= i_im;
      cap_mode <= i_mode;
      cap_thr  <= i_threshold;
      shadow   <= i_mask;
      work     <= i_mask;
      lane_idx <= '0;
      wr_idx   <= '0;
      acc_im   <= '0;
    end else if (step_en) begin
      shadow   <= shadow_next;
      work     <= work_next;
      wr_idx   <= wr_next;
      acc_im   <= acc_next;
      lane_idx <= lane_idx + LIW'(1);
    end
  end

  // publish results only on the edge entering DONE; leftover shadow bits are unbacked
  always_ff @(posedge clk) begin
    if (reset) begin
      o_im       <= '0;
      o_mask     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (finish_en) begin
      o_im       <= acc_next;
      o_mask     <= work_next & ~shadow_next;
      o_count    <= wr_next;
      o_overflow <= |shadow_next;
    end
  end

endmodule

// File: tb/tb_post_sparsity_param.sv
// tb/tb_post_sparsity_param.sv - directed self-checking bench for post_sparsity_param
module tb_post_sparsity_param;

  localparam int IL     = 4;
  localparam int FL     = 16;
  localparam int LANES  = 16;
  localparam int LENGTH = 32;
  localparam int W      = IL + FL;
  localparam int CW     = $clog2(LANES + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic [LANES*W-1:0] i_im;
  logic [LENGTH-1:0]  i_mask;
  logic               i_mode;
  logic [W-1:0]       i_threshold;
  logic               input_ready;
  logic               output_taken;
  logic [LANES*W-1:0] o_im;
  logic [LENGTH-1:0]  o_mask;
  logic [CW-1:0]      o_count;
  logic               o_overflow;
  logic [1:0]         state;

  logic [LANES*W-1:0] exp_im;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  post_sparsity_param #(.IL(IL), .FL(FL), .LANES(LANES), .LENGTH(LENGTH)) dut (
    .clk(clk), .reset(reset), .i_im(i_im), .i_mask(i_mask), .i_mode(i_mode),
    .i_threshold(i_threshold), .input_ready(input_ready), .output_taken(output_taken),
    .o_im(o_im), .o_mask(o_mask), .o_count(o_count), .o_overflow(o_overflow), .state(state)
  );

  task automatic put(input int k, input int val);
    i_im[k*W +: W] = W'(val);
  endtask

  task automatic put_exp(input int k, input int val);
    exp_im[k*W +: W] = W'(val);
  endtask

  task automatic load();
    @(negedge clk); input_ready = 1'b1;
    @(negedge clk); input_ready = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (state != 2'b10 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic release_done();
    @(negedge clk); output_taken = 1'b1;
    @(negedge clk); output_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", state); end
    n_cmp++; if (o_im !== '0) begin n_bad++; $display("FAIL reset_im: got %h want 0", o_im); end
    n_cmp++; if (o_mask !== '0) begin n_bad++; $display("FAIL reset_mask: got %h want 0", o_mask); end
    n_cmp++; if (o_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    reset = 1'b0;
  endtask

  task automatic test_zero_prune();
    int cyc;
    i_im = '0; i_mode = 1'b0; i_threshold = '0; i_mask = 32'h0000_FFFF;
    for (int j = 0; j < 16; j++) put(j, j + 1);
    put(5, 0); put(7, 0); put(8, 0); put(11, 0); put(15, 0);
    exp_im = '0;
    put_exp(0, 1); put_exp(1, 2); put_exp(2, 3); put_exp(3, 4); put_exp(4, 5); put_exp(5, 7);
    put_exp(6, 10); put_exp(7, 11); put_exp(8, 13); put_exp(9, 14); put_exp(10, 15);
    load();
    n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL zp_compute: got %b want 01", state); end
    wait_done(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL zp_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_mask !== 32'h0000_765F) begin n_bad++; $display("FAIL zp_mask: got %h want 0000765f", o_mask); end
    n_cmp++; if (o_count !== 5'd11) begin n_bad++; $display("FAIL zp_count: got %0d want 11", o_count); end
    n_cmp++; if (o_im !== exp_im) begin n_bad++; $display("FAIL zp_im: got %h want %h", o_im, exp_im); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL zp_ovf: got %b want 0", o_overflow); end
    release_done();
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL zp_idle: got %b want 00", state); end
  endtask

  task automatic test_overflow();
    int cyc;
    i_mode = 1'b0; i_mask = 32'hFFFF_FFFF;
    for (int j = 0; j < 16; j++) put(j, 100 + j);
    exp_im = i_im;
    load();
    wait_done(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL ov_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_mask !== 32'h0000_FFFF) begin n_bad++; $display("FAIL ov_mask: got %h want 0000ffff", o_mask); end
    n_cmp++; if (o_count !== 5'd16) begin n_bad++; $display("FAIL ov_count: got %0d want 16", o_count); end
    n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ov_flag: got %b want 1", o_overflow); end
    n_cmp++; if (o_im !== exp_im) begin n_bad++; $display("FAIL ov_im: got %h want %h", o_im, exp_im); end
    release_done();
  endtask

  task automatic test_empty_mask();
    int cyc;
    i_mode = 1'b0; i_mask = '0;
    for (int j = 0; j < 16; j++) put(j, 7 + j);
    load();
    wait_done(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL em_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_mask !== '0) begin n_bad++; $display("FAIL em_mask: got %h want 0", o_mask); end
    n_cmp++; if (o_count !== '0) begin n_bad++; $display("FAIL em_count: got %0d want 0", o_count); end
    n_cmp++; if (o_im !== '0) begin n_bad++; $display("FAIL em_im: got %h want 0", o_im); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL em_ovf: got %b want 0", o_overflow); end
    release_done();
  endtask

  task automatic test_threshold();
    int cyc;
    i_im = '0; i_mode = 1'b1; i_threshold = 20'd4; i_mask = 32'h0000_00F0;
    put(0, 1); put(1, -5); put(2, 3); put(3, 4);
    exp_im = '0; put_exp(0, -5); put_exp(1, 4);
    load();
    wait_done(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL th_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_mask !== 32'h0000_00A0) begin n_bad++; $display("FAIL th_mask: got %h want 000000a0", o_mask); end
    n_cmp++; if (o_count !== 5'd2) begin n_bad++; $display("FAIL th_count: got %0d want 2", o_count); end
    n_cmp++; if (o_im !== exp_im) begin n_bad++; $display("FAIL th_im: got %h want %h", o_im, exp_im); end
    release_done();
  endtask

  task automatic test_saturation();
    int cyc;
    i_im = '0; i_mode = 1'b1; i_mask = 32'h0000_0003;
    put(0, -524288); put(1, -524288);
    i_threshold = 20'h80000;
    load();
    wait_done(cyc);
    n_cmp++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL sat_prune_count: got %0d want 0", o_count); end
    n_cmp++; if (o_mask !== '0) begin n_bad++; $display("FAIL sat_prune_mask: got %h want 0", o_mask); end
    release_done();
    i_threshold = 20'h7FFFF;
    exp_im = '0; put_exp(0, -524288); put_exp(1, -524288);
    load();
    wait_done(cyc);
    n_cmp++; if (o_count !== 5'd2) begin n_bad++; $display("FAIL sat_keep_count: got %0d want 2", o_count); end
    n_cmp++; if (o_mask !== 32'h0000_0003) begin n_bad++; $display("FAIL sat_keep_mask: got %h want 3", o_mask); end
    n_cmp++; if (o_im !== exp_im) begin n_bad++; $display("FAIL sat_keep_im: got %h want %h", o_im, exp_im); end
    release_done();
  endtask

  task automatic test_handshake();
    int cyc;
    i_im = '0; i_mode = 1'b0; i_mask = 32'h0000_00FF;
    for (int j = 0; j < 8; j++) put(j, j + 1);
    load();
    cyc = 0;
    repeat (3) begin @(negedge clk); cyc++; end
    i_mask = 32'hFFFF_FFFF; i_mode = 1'b1; i_threshold = 20'hFFFFF;
    input_ready = 1'b1;
    @(negedge clk); cyc++;
    input_ready = 1'b0;
    while (state != 2'b10 && cyc < 100) begin @(negedge clk); cyc++; end
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL hs_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_count !== 5'd8) begin n_bad++; $display("FAIL hs_count: got %0d want 8", o_count); end
    for (int c = 0; c < 10; c++) begin
      input_ready = (c == 3);
      @(negedge clk);
      n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL hs_hold_state[%0d]: got %b want 10", c, state); end
      n_cmp++; if (o_mask !== 32'h0000_00FF) begin n_bad++; $display("FAIL hs_hold_mask[%0d]: got %h want 000000ff", c, o_mask); end
    end
    input_ready = 1'b1; output_taken = 1'b1;
    @(negedge clk);
    input_ready = 1'b0; output_taken = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL hs_return: got %b want 00", state); end
    output_taken = 1'b1;
    @(negedge clk);
    output_taken = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL hs_idle_stay: got %b want 00", state); end
    n_cmp++; if (o_mask !== 32'h0000_00FF) begin n_bad++; $display("FAIL hs_idle_mask: got %h want 000000ff", o_mask); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    i_im = '0; i_mode = 1'b0; i_mask = 32'hFFFF_FFFF;
    for (int j = 0; j < 16; j++) put(j, 50 + j);
    load();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL ra_state: got %b want 00", state); end
    n_cmp++; if (o_im !== '0) begin n_bad++; $display("FAIL ra_im: got %h want 0", o_im); end
    n_cmp++; if (o_mask !== '0) begin n_bad++; $display("FAIL ra_mask: got %h want 0", o_mask); end
    n_cmp++; if (o_count !== '0) begin n_bad++; $display("FAIL ra_count: got %0d want 0", o_count); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL ra_ovf: got %b want 0", o_overflow); end
    i_im = '0; i_mode = 1'b1; i_threshold = 20'd4; i_mask = 32'h0000_00F0;
    put(0, 1); put(1, -5); put(2, 3); put(3, 4);
    exp_im = '0; put_exp(0, -5); put_exp(1, 4);
    load();
    wait_done(cyc);
    n_cmp++; if (cyc != 16) begin n_bad++; $display("FAIL ra_latency: got %0d want 16", cyc); end
    n_cmp++; if (o_mask !== 32'h0000_00A0) begin n_bad++; $display("FAIL ra_mask2: got %h want 000000a0", o_mask); end
    n_cmp++; if (o_im !== exp_im) begin n_bad++; $display("FAIL ra_im2: got %h want %h", o_im, exp_im); end
    release_done();
  endtask

  initial begin
    reset = 1'b1; i_im = '0; i_mask = '0; i_mode = 1'b0; i_threshold = '0;
    input_ready = 1'b0; output_taken = 1'b0; exp_im = '0;
    test_reset();
    test_zero_prune();
    test_overflow();
    test_empty_mask();
    test_threshold();
    test_saturation();
    test_handshake();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
